// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants and FSM state type for the mux select arbiter.
package mux_sel_arbiter_pkg;

    localparam int NUM_REQ_DEF = 31;
    localparam int SEL_W_DEF   = 5;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        REL  = 2'd2
    } state_t;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests past the last winner,
// find the first set bit, and map its offset back to a lane index.
module mux_sel_arbiter_rr_pick
    import mux_sel_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   winner
);

    logic [NUM_REQ-1:0] rotated;
    int                 shift;
    int                 offset;
    int                 idx;

    always_comb begin
        // NOTE: every variable gets a value before any conditional code, so no latch can be inferred.
        offset  = 0;
        shift   = int'(last) + 1;
        // Bit 0 of the rotated vector is lane last+1; the doubled copy supplies the wrap.
        rotated = NUM_REQ'({req, req} >> shift);
        found   = |rotated;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        idx = shift + offset;
        if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
        end
        winner = SEL_W'(idx);
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for the lane mux; holds sel until done.
// Optional forced release after TIMEOUT busy cycles: MUX_SEL_ARBITER_TIMEOUT_EN.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               timeout_o
);

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_REQ - 1);

    if ((2 ** SEL_W) <= NUM_REQ || TIMEOUT < 1) begin : g_bad_params
        $error("mux_sel_arbiter: requires 2**SEL_W > NUM_REQ and TIMEOUT >= 1");
    end

    state_t             state, state_d;
    logic [SEL_W-1:0]   last, last_d;
    logic [SEL_W-1:0]   sel_d;
    logic               sel_valid_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               found;
    logic [SEL_W-1:0]   winner;
    logic               expire;

    mux_sel_arbiter_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req   (req),
        .last  (last),
        .found (found),
        .winner(winner)
    );

    always_comb begin
        state_d     = state;
        last_d      = last;
        sel_d       = sel;
        sel_valid_d = sel_valid;
        grant_d     = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_d       = winner;
                    sel_valid_d = 1'b1;
                    grant_d     = NUM_REQ'(1) << winner;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Requests are deliberately not looked at here: the mux must not see sel move.
                if (done || expire) begin
                    last_d      = sel;
                    sel_valid_d = 1'b0;
                    grant_d     = '0;
                    state_d     = REL;
                end
            end
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= LAST_RST;
            sel       <= '0;
            sel_valid <= 1'b0;
            grant     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_d;
            last      <= last_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            grant     <= grant_d;
        end
    end

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // done wins over an expiry landing on the same edge.
    assign expire = (state == BUSY) && !done && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            cnt       <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
            timeout_o <= expire;
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
